// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared definitions for the Hack CPU sequencer: state encoding and instruction fields.
package hack_cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_RD, S_EXEC, S_MEM_WR, S_HALT
  } state_t;

  // C-instruction layout: 111a cccc ccdd djjj
  localparam int C_BIT   = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  // dest field is {A, D, M} from bit 5 down to bit 3
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  localparam logic [2:0] JMP_ALWAYS = 3'b111;

  function automatic logic is_c_instr(input logic [15:0] ins);
    return ins[C_BIT];
  endfunction

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Memory and ALU side bus of the Hack CPU sequencer.
interface hack_cpu_ctrl_if #(parameter int ADDR_W = 15);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [15:0]       dmem_wdata;
  logic              dmem_ack;
  logic [15:0]       dmem_rdata;
  logic [15:0]       alu_x;
  logic [15:0]       alu_y;
  logic [5:0]        alu_ctrl;
  logic [15:0]       alu_out;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           alu_x, alu_y, alu_ctrl,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata, alu_out
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           alu_x, alu_y, alu_ctrl,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata, alu_out
  );
endinterface

// File: rtl/hack_cpu_ctrl_jump.sv
// Jump condition from the jjj field and the ALU result flags.
module hack_jump_eval (
  input  logic [2:0]  jjj,
  input  logic [15:0] alu_out,
  output logic        jump
);
  logic zr, ng;

  // j1 = less-than, j2 = equal, j3 = greater-than
  always_comb begin
    zr   = (alu_out == 16'h0000);
    ng   = alu_out[15];
    jump = (jjj[2] & ng) | (jjj[1] & zr) | (jjj[0] & ~ng & ~zr);
  end
endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer: owns A, D, PC and drives imem, dmem and the external ALU.
module hack_cpu_ctrl
  import hack_cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter bit HALT_LOOP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  hack_cpu_ctrl_if.master   bus,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       a_reg,
  output logic [15:0]       d_reg,
  output logic              halted
);

  state_t            state, nxt;
  logic [15:0]       instr, a_old, m_lat, wdata;
  logic              jump, jump_q, halt_req;
  logic [ADDR_W-1:0] pc_inc, tgt;

  hack_jump_eval u_jump (
    .jjj     (instr[JUMP_HI:JUMP_LO]),
    .alu_out (bus.alu_out),
    .jump    (jump)
  );

  assign pc_inc   = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign tgt      = a_old[ADDR_W-1:0];
  // A halt loop is an unconditional jump back onto itself; PC still holds this instruction here
  assign halt_req = HALT_LOOP && (instr[JUMP_HI:JUMP_LO] == JMP_ALWAYS) && (tgt == pc);

  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = tgt;
  assign bus.dmem_wdata = wdata;
  assign bus.alu_x      = d_reg;
  assign bus.alu_y      = instr[A_BIT] ? m_lat : a_reg;
  assign bus.alu_ctrl   = instr[COMP_HI:COMP_LO];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next state and request strobes; requests are pure state decodes so reset kills them at once
  always_comb begin
    nxt          = state;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    halted       = 1'b0;
    unique case (state)
      S_IDLE:   if (run) nxt = S_FETCH;
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!is_c_instr(instr))  nxt = S_FETCH;
        else if (instr[A_BIT])   nxt = S_MEM_RD;
        else                     nxt = S_EXEC;
      end
      S_MEM_RD: begin
        bus.dmem_req = 1'b1;
        if (bus.dmem_ack) nxt = S_EXEC;
      end
      S_EXEC: begin
        if (instr[DEST_M]) nxt = S_MEM_WR;
        else if (halt_req) nxt = S_HALT;
        else               nxt = S_FETCH;
      end
      S_MEM_WR: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = 1'b1;
        if (bus.dmem_ack) nxt = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  nxt = S_IDLE;
    endcase
  end

  // Datapath: A, D, PC, latched instruction, A snapshot, M value and write data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      a_reg  <= '0;
      d_reg  <= '0;
      instr  <= '0;
      a_old  <= '0;
      m_lat  <= '0;
      wdata  <= '0;
      jump_q <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH:  if (bus.imem_ack) instr <= bus.imem_rdata;
        S_DECODE: begin
          if (!is_c_instr(instr)) begin
            a_reg <= instr;
            pc    <= pc_inc;
          end else begin
            a_old <= a_reg;
          end
        end
        S_MEM_RD: if (bus.dmem_ack) m_lat <= bus.dmem_rdata;
        S_EXEC: begin
          if (instr[DEST_D]) d_reg <= bus.alu_out;
          if (instr[DEST_A]) a_reg <= bus.alu_out;
          // A memory write defers the PC update until the write is acknowledged
          if (instr[DEST_M]) begin
            wdata  <= bus.alu_out;
            jump_q <= jump;
          end else begin
            pc <= jump ? tgt : pc_inc;
          end
        end
        S_MEM_WR: if (bus.dmem_ack) pc <= jump_q ? tgt : pc_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for the Hack CPU sequencer with a reference Hack ALU in the environment.
module tb_hack_cpu_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [14:0] pc;
  logic [15:0] a_reg, d_reg;
  logic        halted;
  int          total = 0;
  int          bad   = 0;

  hack_cpu_ctrl_if #(.ADDR_W(15)) bus ();

  hack_cpu_ctrl #(.ADDR_W(15), .HALT_LOOP(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .bus    (bus),
    .pc     (pc),
    .a_reg  (a_reg),
    .d_reg  (d_reg),
    .halted (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? (xx + yy) : (xx & yy);
    return c[0] ? ~o : o;
  endfunction

  always_comb bus.alu_out = hack_alu(bus.alu_x, bus.alu_y, bus.alu_ctrl);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input bit is_imem, input string tag);
    int n = 0;
    while (!(is_imem ? bus.imem_req : bus.dmem_req) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_seen"}, is_imem ? bus.imem_req : bus.dmem_req, 1);
  endtask

  task automatic fetch(input logic [15:0] ins, input int dly, input logic [14:0] exp_pc);
    wait_req(1'b1, "imem");
    chk("imem_addr", bus.imem_addr, exp_pc);
    repeat (dly) begin
      @(negedge clk);
      chk("imem_hold", {bus.imem_req, bus.imem_addr}, {1'b1, exp_pc});
    end
    bus.imem_rdata = ins;
    bus.imem_ack   = 1'b1;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    chk("imem_drop", bus.imem_req, 0);
  endtask

  task automatic dmem(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                      input logic [15:0] rd, input int dly);
    wait_req(1'b0, "dmem");
    chk("dmem_we", bus.dmem_we, we);
    chk("dmem_addr", bus.dmem_addr, addr);
    if (we) chk("dmem_wdata", bus.dmem_wdata, wd);
    repeat (dly) begin
      @(negedge clk);
      chk("dmem_hold", {bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata},
          {1'b1, we, addr, bus.dmem_we ? wd : bus.dmem_wdata});
    end
    bus.dmem_rdata = rd;
    bus.dmem_ack   = 1'b1;
    @(negedge clk);
    bus.dmem_ack   = 1'b0;
    chk("dmem_drop", bus.dmem_req, 0);
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_dmem_req", {bus.dmem_req, bus.dmem_we}, 0);
    chk("rst_regs", {pc, a_reg, d_reg}, 0);
    chk("rst_alu_ctrl", bus.alu_ctrl, 0);
    chk("rst_halted", halted, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_req", bus.imem_req, 0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;  // only sampled in IDLE, program keeps going

    // @7 with immediate ack
    fetch(16'h0007, 0, 15'd0);
    @(negedge clk);
    chk("ainstr_a", a_reg, 16'd7);
    chk("ainstr_pc", pc, 15'd1);
    // D=A with a one-cycle fetch delay
    fetch(16'hEC10, 1, 15'd1);
    @(negedge clk);
    chk("dA_alu_ctrl", bus.alu_ctrl, 6'b110000);
    chk("dA_operands", {bus.alu_x, bus.alu_y}, {16'd0, 16'd7});
    @(negedge clk);
    chk("dA_regs", {d_reg, a_reg, pc}, {16'd7, 16'd7, 15'd2});
    // @21; M=D with 3-cycle ack delay
    fetch(16'h0015, 0, 15'd2);
    @(negedge clk);
    chk("a21", {a_reg, pc}, {16'd21, 15'd3});
    fetch(16'hE308, 0, 15'd3);
    dmem(1'b1, 15'd21, 16'd7, 16'h0, 3);
    chk("mD_pc", {pc, bus.imem_req}, {15'd4, 1'b1});
    // D=M reading 0x8000
    fetch(16'hFC10, 0, 15'd4);
    dmem(1'b0, 15'd21, 16'h0, 16'h8000, 0);
    @(negedge clk);
    chk("dM_regs", {d_reg, a_reg, pc}, {16'h8000, 16'd21, 15'd5});
    // D;JGT with negative D: no jump
    fetch(16'hE301, 0, 15'd5);
    repeat (2) @(negedge clk);
    chk("jgt_nojump_pc", pc, 15'd6);
    // @7; D=A; @12; D;JGT with D=7: jump to 12
    fetch(16'h0007, 0, 15'd6);
    @(negedge clk);
    fetch(16'hEC10, 0, 15'd7);
    repeat (2) @(negedge clk);
    chk("d7", d_reg, 16'd7);
    fetch(16'h000C, 0, 15'd8);
    @(negedge clk);
    chk("a12", {a_reg, pc}, {16'd12, 15'd9});
    fetch(16'hE301, 0, 15'd9);
    repeat (2) @(negedge clk);
    chk("jgt_jump_pc", pc, 15'd12);
    // @13 at PC=12, 0;JMP at PC=13 -> halt loop
    fetch(16'h000D, 0, 15'd12);
    @(negedge clk);
    fetch(16'hEA87, 0, 15'd13);
    @(negedge clk);
    chk("jmp_alu_ctrl", bus.alu_ctrl, 6'b101010);
    @(negedge clk);
    chk("halt_state", {halted, pc, bus.imem_req}, {1'b1, 15'd13, 1'b0});
    repeat (3) @(negedge clk);
    chk("halt_stays", {halted, bus.imem_req, bus.dmem_req, a_reg, d_reg},
        {1'b1, 1'b0, 1'b0, 16'd13, 16'd7});

    // Reset out of HALT, then reset in the middle of a pending M read
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_from_halt", {halted, pc, a_reg, d_reg}, 0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    fetch(16'hFC10, 0, 15'd0);
    @(negedge clk);
    chk("mrd_pending", {bus.dmem_req, bus.dmem_we, bus.dmem_addr}, {1'b1, 1'b0, 15'd0});
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_drops_req", {bus.dmem_req, bus.imem_req}, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.dmem_rdata = 16'h1234;
    bus.dmem_ack   = 1'b1;
    @(negedge clk);
    bus.dmem_ack   = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", {bus.dmem_req, bus.imem_req, pc, d_reg, halted}, 0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    fetch(16'h0003, 0, 15'd0);
    @(negedge clk);
    chk("restart", {a_reg, pc}, {16'd3, 15'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
